// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch/decode queue.
package fetch_decode_queue_pkg;

  localparam int WORD_W = 32;

  // sll $0,$0,0 -- what decode sees when nothing real is presented
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] pc_plus_4;
  } fdq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_storage.sv
// fdq_storage: DEPTH x 64-bit entry array, one sync write port, one async
// read port. Contents are never reset; validity is tracked by the control.
module fdq_storage
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [2*WORD_W-1:0]   wr_data,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [2*WORD_W-1:0]   rd_data
);

  fdq_entry_t mem [DEPTH];

  // write the entry at the tail slot
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: small FIFO of {instruction, pc_plus_4} between fetch
// and decode. Full raises stall_f (registered count only), a taken branch
// in decode (flush_d) empties the queue and drops the incoming entry.
// Optional macro FDQ_BYPASS_EN: when the queue is empty, an offered entry
// is shown to decode in the same cycle and only written if decode stalls.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int                DEPTH     = 2,
  parameter logic [WORD_W-1:0] NOP_INSTR = fetch_decode_queue_pkg::NOP_INSTR
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] instruction_f,
  input  logic [WORD_W-1:0] pc_plus_4_f,
  input  logic              valid_f,
  output logic              stall_f,
  input  logic              stall_d,
  input  logic              flush_d,
  output logic [WORD_W-1:0] instruction_d,
  output logic [WORD_W-1:0] pc_plus_4_d,
  output logic              valid_d
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             has_entry, push, pop, bypass;
  fdq_entry_t       wr_entry, head_entry;

  assign has_entry = (count != '0);
  assign stall_f   = (count == FULL_CNT);

`ifdef FDQ_BYPASS_EN
  // empty queue: show the fetch entry straight through; keep it only if
  // decode cannot take it this cycle
  assign bypass  = reset_n & ~has_entry & valid_f & ~flush_d;
  assign push    = valid_f & ~stall_f & ~flush_d & ~(bypass & ~stall_d);
`else
  assign bypass  = 1'b0;
  assign push    = valid_f & ~stall_f & ~flush_d;
`endif
  assign pop     = has_entry & ~stall_d & ~flush_d;
  assign valid_d = has_entry | bypass;

  assign wr_entry.instruction = instruction_f;
  assign wr_entry.pc_plus_4   = pc_plus_4_f;

  fdq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (tail),
    .wr_data (wr_entry),
    .rd_addr (head),
    .rd_data (head_entry)
  );

  // head entry when occupied, bypassed fetch entry when allowed, else NOP
  always_comb begin
    instruction_d = NOP_INSTR;
    pc_plus_4_d   = '0;
    if (has_entry) begin
      instruction_d = head_entry.instruction;
      pc_plus_4_d   = head_entry.pc_plus_4;
    end else if (bypass) begin
      instruction_d = instruction_f;
      pc_plus_4_d   = pc_plus_4_f;
    end
  end

  // pointer/occupancy update; flush wins over push and pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_d) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instruction_f, pc_plus_4_f;
  logic        valid_f, stall_f, stall_d, flush_d;
  logic [31:0] instruction_d, pc_plus_4_d;
  logic        valid_d;

  int n_vec = 0;
  int n_bad = 0;

  // model: queue of {instruction, pc_plus_4}, oldest at index 0
  logic [63:0] mq [$];

  fetch_decode_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .instruction_f (instruction_f),
    .pc_plus_4_f   (pc_plus_4_f),
    .valid_f       (valid_f),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .instruction_d (instruction_d),
    .pc_plus_4_d   (pc_plus_4_d),
    .valid_d       (valid_d)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive inputs, check outputs at the falling edge, then advance
  // the model at the rising edge
  task automatic step(input logic rn, input logic vf, input logic [31:0] ins,
                      input logic [31:0] pc, input logic sd, input logic fl);
    logic        bp, full, exp_v;
    logic [31:0] exp_i, exp_p;
    reset_n = rn; valid_f = vf; instruction_f = ins; pc_plus_4_f = pc;
    stall_d = sd; flush_d = fl;
    @(negedge clock);
    if (!rn) mq.delete();
`ifdef FDQ_BYPASS_EN
    bp = rn && mq.size() == 0 && vf && !fl;
`else
    bp = 1'b0;
`endif
    full  = (mq.size() == DEPTH);
    exp_v = (mq.size() != 0) || bp;
    exp_i = (mq.size() != 0) ? mq[0][63:32] : (bp ? ins : NOP);
    exp_p = (mq.size() != 0) ? mq[0][31:0]  : (bp ? pc  : 32'h0);
    chk("valid_d",       {31'b0, valid_d}, {31'b0, exp_v});
    chk("stall_f",       {31'b0, stall_f}, {31'b0, full});
    chk("instruction_d", instruction_d, exp_i);
    chk("pc_plus_4_d",   pc_plus_4_d,   exp_p);
    @(posedge clock);
    if (!rn || fl) mq.delete();
    else if (bp && !sd) ;  // consumed straight through
    else begin
      if (mq.size() != 0 && !sd) void'(mq.pop_front());
      if (vf && !full) mq.push_back({ins, pc});
    end
    #1;
  endtask

  initial begin
    reset_n = 1'b0; valid_f = 1'b0; instruction_f = '0; pc_plus_4_f = '0;
    stall_d = 1'b0; flush_d = 1'b0;
    #1;
    // reset held with fetch offering
    step(0, 1, 32'h1111_1111, 32'h4, 0, 0);
    step(0, 1, 32'h2222_2222, 32'h8, 0, 0);
    // first push after release
    step(1, 1, 32'h2008_0005, 32'h0000_0004, 1, 0);
    step(1, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 32'h0, 0, 0);
    // streaming
    for (int i = 0; i < 4; i++) step(1, 1, 32'hA000_0000 + i, 32'h100 + 4*i, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // fill with decode stalled, then drain
    for (int i = 0; i < 3; i++) step(1, 1, 32'hB000_0000 + i, 32'h200 + 4*i, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    // flush with a full queue and an incoming entry
    for (int i = 0; i < 2; i++) step(1, 1, 32'hC000_0000 + i, 32'h300 + 4*i, 1, 0);
    step(1, 1, 32'hC000_0002, 32'h308, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // simultaneous push/pop at count=1, pointers wrap
    step(1, 1, 32'hD000_0000, 32'h400, 1, 0);
    for (int i = 1; i < 5; i++) step(1, 1, 32'hD000_0000 + i, 32'h400 + 4*i, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // empty queue, fetch offers with decode ready
    step(1, 1, 32'h8C09_0000, 32'h500, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // reset dropped mid-operation with a full queue
    for (int i = 0; i < 2; i++) step(1, 1, 32'hE000_0000 + i, 32'h600 + 4*i, 1, 0);
    step(0, 1, 32'hE000_0002, 32'h608, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 3) != 0), $urandom, $urandom,
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) < 8));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
